// File: rtl/operand_stage_pkg.sv
// Shared widths and helpers for the decode-side operand fetch stage.
package operand_stage_pkg;

  localparam int unsigned WordWidth  = 32;
  localparam int unsigned RegAddrW   = 5;
  localparam int unsigned CtrlW      = 16;
  localparam int unsigned ZeroRegIdx = 0;
  localparam int unsigned StallCntW  = 32;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [StallCntW-1:0] sat_inc(input logic [StallCntW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/operand_stage_fwd_mux.sv
// Per-operand resolution: picks zero, a forwarded result or the register-file value,
// and flags a load-use hazard on that operand.
module operand_stage_fwd_mux
  import operand_stage_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WordWidth,
  parameter int unsigned REG_ADDR_W = RegAddrW
) (
  input  logic [REG_ADDR_W-1:0] idx_i,
  input  logic                  use_i,
  input  logic [WORD_WIDTH-1:0] rf_data_i,
  input  logic                  f1_valid_i,
  input  logic [REG_ADDR_W-1:0] f1_addr_i,
  input  logic [WORD_WIDTH-1:0] f1_data_i,
  input  logic                  f1_is_load_i,
  input  logic                  f2_valid_i,
  input  logic [REG_ADDR_W-1:0] f2_addr_i,
  input  logic [WORD_WIDTH-1:0] f2_data_i,
  input  logic                  held_valid_i,
  input  logic                  held_is_load_i,
  input  logic                  held_wr_en_i,
  input  logic [REG_ADDR_W-1:0] held_dst_i,
  output logic [WORD_WIDTH-1:0] val_o,
  output logic                  hazard_o
);

  logic is_zero;
  logic f1_hit;
  logic f2_hit;
  logic held_hit;

  always_comb begin
    is_zero  = (idx_i == REG_ADDR_W'(ZeroRegIdx));
    f1_hit   = f1_valid_i && (f1_addr_i == idx_i);
    f2_hit   = f2_valid_i && (f2_addr_i == idx_i);
    held_hit = held_valid_i && held_is_load_i && held_wr_en_i && (held_dst_i == idx_i);
  end

  // f1 is the younger result, so it wins over f2; a load in f1 has no data yet.
  always_comb begin
    val_o = rf_data_i;
    if (is_zero) begin
      val_o = '0;
    end else if (f1_hit && !f1_is_load_i) begin
      val_o = f1_data_i;
    end else if (f2_hit) begin
      val_o = f2_data_i;
    end
  end

  always_comb begin
    hazard_o = use_i && !is_zero && (held_hit || (f1_hit && f1_is_load_i));
  end

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage: register-file read, EX/MEM and MEM/WB forwarding, load-use stall,
// and the ID/EX pipeline register with a valid/ready handshake toward execute.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WordWidth,
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter int unsigned CTRL_W     = CtrlW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs,
  input  logic [REG_ADDR_W-1:0] in_rt,
  input  logic                  in_use_rs,
  input  logic                  in_use_rt,
  input  logic [REG_ADDR_W-1:0] in_dst,
  input  logic                  in_wr_en,
  input  logic                  in_is_load,
  input  logic [WORD_WIDTH-1:0] in_imm,
  input  logic [CTRL_W-1:0]     in_ctrl,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [WORD_WIDTH-1:0] rf_rdata1,
  input  logic [WORD_WIDTH-1:0] rf_rdata2,
  input  logic                  f1_valid,
  input  logic [REG_ADDR_W-1:0] f1_addr,
  input  logic [WORD_WIDTH-1:0] f1_data,
  input  logic                  f1_is_load,
  input  logic                  f2_valid,
  input  logic [REG_ADDR_W-1:0] f2_addr,
  input  logic [WORD_WIDTH-1:0] f2_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_rs_val,
  output logic [WORD_WIDTH-1:0] out_rt_val,
  output logic [REG_ADDR_W-1:0] out_dst,
  output logic                  out_wr_en,
  output logic                  out_is_load,
  output logic [WORD_WIDTH-1:0] out_imm,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [StallCntW-1:0]  stall_cnt
);

  logic                  valid_q, valid_d;
  logic [WORD_WIDTH-1:0] rs_val_q, rs_val_d;
  logic [WORD_WIDTH-1:0] rt_val_q, rt_val_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic                  wr_en_q, wr_en_d;
  logic                  is_load_q, is_load_d;
  logic [WORD_WIDTH-1:0] imm_q, imm_d;
  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [StallCntW-1:0]  stall_q, stall_d;

  logic [WORD_WIDTH-1:0] rs_val;
  logic [WORD_WIDTH-1:0] rt_val;
  logic                  haz_rs;
  logic                  haz_rt;
  logic                  hazard;
  logic                  slot_free;
  logic                  accept;

  assign rf_raddr1 = in_rs;
  assign rf_raddr2 = in_rt;

  operand_stage_fwd_mux #(
    .WORD_WIDTH (WORD_WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs (
    .idx_i          (in_rs),
    .use_i          (in_use_rs),
    .rf_data_i      (rf_rdata1),
    .f1_valid_i     (f1_valid),
    .f1_addr_i      (f1_addr),
    .f1_data_i      (f1_data),
    .f1_is_load_i   (f1_is_load),
    .f2_valid_i     (f2_valid),
    .f2_addr_i      (f2_addr),
    .f2_data_i      (f2_data),
    .held_valid_i   (valid_q),
    .held_is_load_i (is_load_q),
    .held_wr_en_i   (wr_en_q),
    .held_dst_i     (dst_q),
    .val_o          (rs_val),
    .hazard_o       (haz_rs)
  );

  operand_stage_fwd_mux #(
    .WORD_WIDTH (WORD_WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rt (
    .idx_i          (in_rt),
    .use_i          (in_use_rt),
    .rf_data_i      (rf_rdata2),
    .f1_valid_i     (f1_valid),
    .f1_addr_i      (f1_addr),
    .f1_data_i      (f1_data),
    .f1_is_load_i   (f1_is_load),
    .f2_valid_i     (f2_valid),
    .f2_addr_i      (f2_addr),
    .f2_data_i      (f2_data),
    .held_valid_i   (valid_q),
    .held_is_load_i (is_load_q),
    .held_wr_en_i   (wr_en_q),
    .held_dst_i     (dst_q),
    .val_o          (rt_val),
    .hazard_o       (haz_rt)
  );

  always_comb begin
    hazard    = haz_rs || haz_rt;
    slot_free = !valid_q || out_ready;
    // A flush discards whatever is offered, so the upstream is always released.
    in_ready  = flush || (!hazard && slot_free);
    accept    = in_valid && in_ready && !flush;
  end

  always_comb begin
    valid_d   = valid_q;
    rs_val_d  = rs_val_q;
    rt_val_d  = rt_val_q;
    dst_d     = dst_q;
    wr_en_d   = wr_en_q;
    is_load_d = is_load_q;
    imm_d     = imm_q;
    ctrl_d    = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      rs_val_d  = rs_val;
      rt_val_d  = rt_val;
      dst_d     = in_dst;
      wr_en_d   = in_wr_en;
      is_load_d = in_is_load;
      imm_d     = in_imm;
      ctrl_d    = in_ctrl;
    end else if (slot_free) begin
      // Slot drained with nothing (or only a stalled instruction) to refill it: bubble.
      valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (in_valid && hazard && !flush) begin
      stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      rs_val_q  <= '0;
      rt_val_q  <= '0;
      dst_q     <= '0;
      wr_en_q   <= 1'b0;
      is_load_q <= 1'b0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_val_q  <= rs_val_d;
      rt_val_q  <= rt_val_d;
      dst_q     <= dst_d;
      wr_en_q   <= wr_en_d;
      is_load_q <= is_load_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_rs_val  = rs_val_q;
  assign out_rt_val  = rt_val_q;
  assign out_dst     = dst_q;
  assign out_wr_en   = wr_en_q;
  assign out_is_load = is_load_q;
  assign out_imm     = imm_q;
  assign out_ctrl    = ctrl_q;
  assign stall_cnt   = stall_q;

`ifndef SYNTHESIS
  // A held instruction must not change while execute is applying backpressure.
  hold_stable_a : assert property (@(posedge clk) disable iff (!rst)
    (valid_q && !out_ready && !flush) |=>
      (valid_q && $stable(rs_val_q) && $stable(rt_val_q) && $stable(imm_q) &&
       $stable(ctrl_q) && $stable(dst_q)));
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: a vector table of single-cycle forwarding/hazard cases
// followed by hand-written load-use, backpressure, flush and reset sequences.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt, in_dst;
  logic        in_use_rs, in_use_rt, in_wr_en, in_is_load;
  logic [31:0] in_imm;
  logic [15:0] in_ctrl;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        f1_valid, f1_is_load, f2_valid;
  logic [4:0]  f1_addr, f2_addr;
  logic [31:0] f1_data, f2_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_rs_val, out_rt_val, out_imm;
  logic [4:0]  out_dst;
  logic        out_wr_en, out_is_load;
  logic [15:0] out_ctrl;
  logic [31:0] stall_cnt;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] stall_exp = 32'd0;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_use_rs   (in_use_rs),
    .in_use_rt   (in_use_rt),
    .in_dst      (in_dst),
    .in_wr_en    (in_wr_en),
    .in_is_load  (in_is_load),
    .in_imm      (in_imm),
    .in_ctrl     (in_ctrl),
    .rf_raddr1   (rf_raddr1),
    .rf_raddr2   (rf_raddr2),
    .rf_rdata1   (rf_rdata1),
    .rf_rdata2   (rf_rdata2),
    .f1_valid    (f1_valid),
    .f1_addr     (f1_addr),
    .f1_data     (f1_data),
    .f1_is_load  (f1_is_load),
    .f2_valid    (f2_valid),
    .f2_addr     (f2_addr),
    .f2_data     (f2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rs_val  (out_rs_val),
    .out_rt_val  (out_rt_val),
    .out_dst     (out_dst),
    .out_wr_en   (out_wr_en),
    .out_is_load (out_is_load),
    .out_imm     (out_imm),
    .out_ctrl    (out_ctrl),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt;
    logic        use_rs, use_rt;
    logic [31:0] rf1, rf2;
    logic        f1v;
    logic [4:0]  f1a;
    logic [31:0] f1d;
    logic        f1l;
    logic        f2v;
    logic [4:0]  f2a;
    logic [31:0] f2d;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic [4:0]  dst;
    logic        exp_ready;
    logic [31:0] exp_rs, exp_rt;
  } vec_t;

  localparam int NumVec = 10;
  vec_t vecs [NumVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_inputs();
    in_valid = 1'b0; in_rs = 5'd0; in_rt = 5'd0; in_use_rs = 1'b0; in_use_rt = 1'b0;
    in_dst = 5'd0; in_wr_en = 1'b0; in_is_load = 1'b0; in_imm = 32'd0; in_ctrl = 16'd0;
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
    f1_valid = 1'b0; f1_addr = 5'd0; f1_data = 32'd0; f1_is_load = 1'b0;
    f2_valid = 1'b0; f2_addr = 5'd0; f2_data = 32'd0;
    flush = 1'b0;
  endtask

  task automatic drv_instr(input logic [4:0] rs, input logic [4:0] rt, input logic use_rs,
                           input logic use_rt, input logic [4:0] dst, input logic is_load,
                           input logic [31:0] imm);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_use_rs = use_rs; in_use_rt = use_rt;
    in_dst = dst; in_wr_en = 1'b1; in_is_load = is_load; in_imm = imm; in_ctrl = imm[15:0];
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    logic  exp_valid;
    @(negedge clk);
    in_valid = v.valid; in_rs = v.rs; in_rt = v.rt; in_use_rs = v.use_rs; in_use_rt = v.use_rt;
    rf_rdata1 = v.rf1; rf_rdata2 = v.rf2;
    f1_valid = v.f1v; f1_addr = v.f1a; f1_data = v.f1d; f1_is_load = v.f1l;
    f2_valid = v.f2v; f2_addr = v.f2a; f2_data = v.f2d;
    in_imm = v.imm; in_ctrl = v.ctrl; in_dst = v.dst; in_wr_en = 1'b1; in_is_load = 1'b0;
    #1;
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, v.exp_ready});
    chk({tag, ".rf_raddr1"}, {27'd0, rf_raddr1}, {27'd0, v.rs});
    if (v.valid && !v.exp_ready) stall_exp++;
    exp_valid = v.valid && v.exp_ready;
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    chk({tag, ".stall_cnt"}, stall_cnt, stall_exp);
    if (exp_valid) begin
      chk({tag, ".out_rs_val"}, out_rs_val, v.exp_rs);
      chk({tag, ".out_rt_val"}, out_rt_val, v.exp_rt);
      chk({tag, ".out_imm"}, out_imm, v.imm);
      chk({tag, ".out_ctrl"}, {16'd0, out_ctrl}, {16'd0, v.ctrl});
      chk({tag, ".out_dst"}, {27'd0, out_dst}, {27'd0, v.dst});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stall_before;
    int          bubbles;

    // valid rs rt urs urt rf1 rf2 f1v f1a f1d f1l f2v f2a f2d imm ctrl dst rdy exp_rs exp_rt
    vecs[0] = '{1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 32'h11, 32'h66, 1'b1, 5'd5, 32'h33, 1'b0,
                1'b1, 5'd5, 32'h22, 32'h100, 16'h0A01, 5'd10, 1'b1, 32'h33, 32'h66};
    vecs[1] = '{1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 32'h11, 32'h66, 1'b0, 5'd5, 32'h33, 1'b0,
                1'b1, 5'd5, 32'h22, 32'h101, 16'h0A02, 5'd11, 1'b1, 32'h22, 32'h66};
    vecs[2] = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 32'hBEEF, 32'hBEEF, 1'b1, 5'd0, 32'hDEAD, 1'b0,
                1'b1, 5'd0, 32'hF00D, 32'h102, 16'h0A03, 5'd12, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 32'h3, 32'h90, 1'b1, 5'd9, 32'hBAD, 1'b1,
                1'b1, 5'd9, 32'h99, 32'h103, 16'h0A04, 5'd13, 1'b1, 32'h3, 32'h99};
    vecs[4] = '{1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 32'h40, 32'h20, 1'b1, 5'd4, 32'hBAD, 1'b1,
                1'b0, 5'd0, 32'h0, 32'h104, 16'h0A05, 5'd14, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 32'h20, 32'h44, 1'b1, 5'd4, 32'hBAD, 1'b1,
                1'b0, 5'd0, 32'h0, 32'h105, 16'h0A06, 5'd15, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 5'd4, 5'd2, 1'b0, 1'b1, 32'h44, 32'h20, 1'b1, 5'd4, 32'hBAD, 1'b1,
                1'b0, 5'd0, 32'h0, 32'h106, 16'h0A07, 5'd16, 1'b1, 32'h44, 32'h20};
    vecs[7] = '{1'b1, 5'd8, 5'd7, 1'b1, 1'b1, 32'h80, 32'h70, 1'b1, 5'd8, 32'h88, 1'b0,
                1'b1, 5'd7, 32'h77, 32'h107, 16'h0A08, 5'd17, 1'b1, 32'h88, 32'h77};
    vecs[8] = '{1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b0, 5'd0, 32'h0, 32'h0, 16'h0, 5'd0, 1'b1, 32'h0, 32'h0};
    vecs[9] = '{1'b1, 5'd31, 5'd30, 1'b1, 1'b1, 32'h1, 32'h2, 1'b0, 5'd31, 32'hBAD, 1'b0,
                1'b1, 5'd31, 32'hF2F2, 32'h109, 16'h0A0A, 5'd19, 1'b1, 32'hF2F2, 32'h2};

    clr_inputs();
    out_ready = 1'b1;
    rst = 1'b0;
    #2;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.stall_cnt", stall_cnt, 32'd0);
    chk("reset.out_rs_val", out_rs_val, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NumVec; i++) apply_vec(vecs[i], i);

    // Load r7, then a dependent add right behind it: two bubbles, data from MEM/WB.
    @(negedge clk);
    clr_inputs();
    drv_instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 32'h200);
    @(posedge clk); #1;
    chk("lu.load_held", {30'd0, out_valid, out_is_load}, 32'd3);
    @(negedge clk);
    drv_instr(5'd7, 5'd7, 1'b1, 1'b1, 5'd1, 1'b0, 32'h201);
    rf_rdata1 = 32'hBAD0; rf_rdata2 = 32'hBAD1;
    #1;
    chk("lu.ready_c1", {31'd0, in_ready}, 32'd0);
    stall_exp++;
    bubbles = 0;
    @(posedge clk); #1;
    if (!out_valid) bubbles++;
    @(negedge clk);
    f1_valid = 1'b1; f1_addr = 5'd7; f1_is_load = 1'b1; f1_data = 32'hBAD2;
    #1;
    chk("lu.ready_c2", {31'd0, in_ready}, 32'd0);
    stall_exp++;
    @(posedge clk); #1;
    if (!out_valid) bubbles++;
    chk("lu.bubbles", bubbles, 32'd2);
    @(negedge clk);
    f1_valid = 1'b0;
    f2_valid = 1'b1; f2_addr = 5'd7; f2_data = 32'h44;
    #1;
    chk("lu.ready_c3", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("lu.out_valid", {31'd0, out_valid}, 32'd1);
    chk("lu.rs_val", out_rs_val, 32'h44);
    chk("lu.rt_val", out_rt_val, 32'h44);
    chk("lu.stall_cnt", stall_cnt, stall_exp);

    // Backpressure: EX stalls for three cycles while the next instruction waits.
    @(negedge clk);
    clr_inputs();
    drv_instr(5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0, 32'hA1);
    @(posedge clk); #1;
    chk("bp.first_held", out_imm, 32'hA1);
    @(negedge clk);
    out_ready = 1'b0;
    drv_instr(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b0, 32'hB2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp.in_ready%0d", c), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("bp.hold_imm%0d", c), out_imm, 32'hA1);
      chk($sformatf("bp.hold_valid%0d", c), {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("bp.second_out", out_imm, 32'hB2);
    chk("bp.second_valid", {31'd0, out_valid}, 32'd1);

    // Flush while a load-use stall is in progress.
    @(negedge clk);
    clr_inputs();
    drv_instr(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 32'h300);
    @(posedge clk); #1;
    @(negedge clk);
    drv_instr(5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 32'h301);
    rf_rdata1 = 32'h77;
    #1;
    chk("fl.ready_stall", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    #1;
    chk("fl.ready_flush", {31'd0, in_ready}, 32'd1);
    stall_before = stall_exp;
    @(posedge clk); #1;
    chk("fl.out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl.stall_cnt", stall_cnt, stall_before);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl.ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("fl.refill_rs", out_rs_val, 32'h77);

    // Asynchronous reset in mid-cycle while the output register is full.
    @(negedge clk);
    clr_inputs();
    drv_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 32'h400);
    rf_rdata1 = 32'h5; rf_rdata2 = 32'h6;
    @(posedge clk); #1;
    chk("rst.pre_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    stall_exp = 32'd0;
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_rs_val", out_rs_val, 32'd0);
    chk("rst.out_imm", out_imm, 32'd0);
    chk("rst.stall_cnt", stall_cnt, stall_exp);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drv_instr(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0, 32'h401);
    @(posedge clk); #1;
    chk("rst.restart_valid", {31'd0, out_valid}, 32'd1);
    chk("rst.restart_rt", out_rt_val, 32'h6);
    @(negedge clk);
    clr_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Decode-side operand fetch stage placed directly upstream of the register file.
- Drives the two register-file read addresses and takes back the read values.
- Overrides stale values with forwarded results from EX/MEM and MEM/WB, and stalls on load-use hazards.
- Holds the ID/EX pipeline register that feeds the execute stage through a valid/ready handshake.

Parameters:
WORD_WIDTH, 32, datapath word width
REG_ADDR_W, 5, register index width (32 registers; register 0 hard-wired to zero)
CTRL_W, 16, opaque decoded-control bundle passed to EX unmodified

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
in_valid  in  1  decoded instruction presented
in_ready  out  1  stage accepts instruction this cycle
in_rs / in_rt  in  REG_ADDR_W  source register indices
in_use_rs / in_use_rt  in  1  source actually read by instruction
in_dst  in  REG_ADDR_W  destination index
in_wr_en  in  1  instruction writes in_dst
in_is_load  in  1  instruction is a load
in_imm  in  WORD_WIDTH  extended immediate
in_ctrl  in  CTRL_W  decoded control
rf_raddr1 / rf_raddr2  out  REG_ADDR_W  register-file read addresses (= in_rs / in_rt, combinational)
rf_rdata1 / rf_rdata2  in  WORD_WIDTH  register-file read data (combinational)
f1_valid, f1_addr, f1_data, f1_is_load  in  1/REG_ADDR_W/WORD_WIDTH/1  EX/MEM forward source
f2_valid, f2_addr, f2_data  in  1/REG_ADDR_W/WORD_WIDTH  MEM/WB forward source (includes load data)
flush  in  1  squash held and incoming instruction
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX consumes this cycle
out_rs_val / out_rt_val  out  WORD_WIDTH  resolved operands
out_dst, out_wr_en, out_is_load, out_imm, out_ctrl  out  as inputs  registered copies
stall_cnt  out  32  cycles lost to hazard stalls, saturating

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0 and all out_* payload=0; stall_cnt=0. in_ready stays combinational and resets to 1.
- Register-file writes land on the falling edge, so a WB write is visible to the same-cycle read. No WB-stage forwarding port is needed.
- Operand resolution, rs shown (rt identical):
  - index 0 gives 0;
  - else f1_valid && f1_addr==rs && !f1_is_load gives f1_data;
  - else f2_valid && f2_addr==rs gives f2_data;
  - else rf_rdata1.
  - f1 has priority over f2 because it is the newer result.
- Hazard (combinational), asserted when a used, non-zero source matches either:
  - the held instruction: out_valid && out_is_load && out_wr_en && out_dst==src; or
  - the EX/MEM load: f1_valid && f1_is_load && f1_addr==src.
- Ready logic: in_ready = !hazard && (!out_valid || out_ready), or in_ready = 1 when flush.
- Transfer: in_valid && in_ready && !flush loads the ID/EX register with resolved operands and payload; out_valid=1.
- Bubble: hazard && (!out_valid || out_ready) sets out_valid=0 next cycle. stall_cnt increments every cycle that in_valid && hazard, saturating at 0xFFFF_FFFF.
- Hold: out_valid && !out_ready keeps all outputs stable, whether or not the upstream is waiting.
- Flush has priority over everything: next edge out_valid=0; the incoming instruction is discarded and not counted.
- Latency: one cycle from accept to out_valid. Throughput is one per cycle with no hazards.
- Load-use distance: a dependent instruction immediately behind a load suffers 2 bubbles; one slot behind suffers 1.

Decomposition:
- Shared package: WORD_WIDTH, REG_ADDR_W, CTRL_W, and the zero-register index constant.
- One sub-module, fwd_mux: pure combinational per-operand resolution (index, use bit, rf data, f1/f2 fields gives value and hazard bit). Instantiated twice.

Test Plan:
- Reset mid-stream: drive rst=0 asynchronously while out_valid=1 -> out_valid=0 and outputs 0 immediately. Restart accepts next instruction in 1 cycle.
- Forward priority: rs=5, rf_rdata1=0x11, f2 addr5=0x22, f1 addr5=0x33 (non-load) -> out_rs_val=0x33. Drop f1 -> 0x22.
- Zero register: rs=0 with f1 addr0=0xDEAD -> out_rs_val=0.
- Load-use: load r7 followed by add r1,r7,r7 with f2 delivering 0x44 on the third cycle -> 2 bubbles (out_valid low 2 cycles), stall_cnt=2, add carries 0x44 in both operands.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. Release -> next instruction out one cycle later.
- Flush during hazard stall -> out_valid=0 next edge, in_ready=1, stall_cnt unchanged that cycle.
